cache_data_array_2p: RTL
========================

# cache_data_array_2p

Parametrised two-port successor to the single-port cache data array macro model. It has one read/write port (port 0) with a byte-granular write mask, plus one read-only port (port 1) for the lookup/writeback path. Both ports have registered outputs and defined read-during-write forwarding. A built-in clear sequencer fills every word with a fixed value after reset or on request, and reports readiness. It sits under each cache way's data SRAM wrapper and replaces the fixed 32×256 model.

## Interface
- DATA_WIDTH, 256: word width in bits; must be a multiple of WMASK_GRAN.
- ADDR_WIDTH, 5: address width; depth = 2**ADDR_WIDTH.
- WMASK_GRAN, 8: bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_GRAN (derived, not overridable).
- INIT_VALUE, '0: DATA_WIDTH value written by the clear sequencer.
- CLEAR_ON_RESET, 1: 1 = run the clear sequence after reset; 0 = ready immediately, contents undefined.
- clk0  in  1  clock; all state updates on rising edge.
- rst0_n  in  1  reset, asynchronous, active-low.
- clr_req  in  1  start a clear sequence; sampled only while ready=1.
- ready  out  1  1 = array accepts port requests.
- csb0  in  1  port 0 select, active-low.
- web0  in  1  port 0 write enable, active-low.
- wmask0  in  NUM_WMASKS  per-lane write enable.
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data, registered.
- csb1  in  1  port 1 select, active-low.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data, registered.

## Operation
- FSM states: CLEAR, READY.
  - Reset enters CLEAR with clear counter = 0 if CLEAR_ON_RESET=1; otherwise it enters READY.
- CLEAR:
  - Each edge writes INIT_VALUE to mem[counter] and increments the counter.
  - The edge that writes address depth-1 moves to READY.
  - ready=0 throughout; csb0/csb1 are treated as high, so requests are dropped and dout0/dout1 hold.
- READY:
  - clr_req=1 on an edge moves to CLEAR with counter=0. Port requests sampled on that same edge are dropped (clear has priority).
- Port 0 write (csb0=0, web0=0): each lane i with wmask0[i]=1 writes din0 bits [i*G+G-1 : i*G] into mem[addr0]; other lanes keep their value. dout0 holds.
- Port 0 read (csb0=0, web0=1): dout0 <= mem[addr0].
- Port 1 read (csb1=0): dout1 <= mem[addr1].
- Collision: port 1 read and port 0 write to the same address on the same edge.
  - dout1 returns new data: the din0 lane where wmask0 is set, the old mem lane otherwise.
  - wmask0 all-zero: dout1 returns the old word.
- Deselected port: its dout holds its last value.
- Reset mid-CLEAR or mid-operation: counter and outputs reinitialise as below; mem is not reset except via the sequencer.

## Timing
- Request sampled at edge N.
  - Write is visible in mem after edge N.
  - dout0/dout1 are valid after edge N, i.e. one-cycle read latency. A read of the address written at edge N returns the new data from edge N+1.
- Reset values: dout0=0, dout1=0. ready=0 if CLEAR_ON_RESET=1, else ready=1.
- Clear after reset: ready rises after the 2**ADDR_WIDTH-th edge following rst0_n deassertion.
- clr_req at edge N: ready=0 after N; clear writes occur on edges N+1 .. N+2**ADDR_WIDTH; ready=1 after edge N+2**ADDR_WIDTH.
- No back-pressure signal other than ready. Callers must not issue requests while ready=0.

## Structure
- Shared package sram_pkg:
  - state enum {CLEAR, READY}
  - a localparam function computing NUM_WMASKS
  - a lane-merge function (old, new, mask, gran) → merged word, used by both the write path and the collision bypass
- Sub-module sram_clear_seq: FSM, counter, ready, clear write strobe/address. Top-level muxes the clear write into port 0's write path.
- Storage is a plain reg array with no reset.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=5 → ready=0 for 32 edges, then 1; read of every address returns INIT_VALUE=0.
- Write addr0=3, din0=all 0xA5 bytes, wmask0=0x0000_000F; next read addr0=3 → low 4 bytes 0xA5, rest 0.
- Same edge: port 0 writes addr 7 with mask 0x1, din0 byte0=0x5A; port 1 reads addr 7 → dout1 byte0=0x5A, other bytes old value.
- clr_req=1 with csb0=0/web0=0 on the same edge → write dropped, ready=0 next cycle, all words INIT_VALUE after 32 edges, dout0/dout1 unchanged during clear.
- rst0_n pulsed low at counter=10 during clear → dout0=dout1=0 immediately, clear restarts at address 0, ready high 32 edges after release.
- Parameter sweep DATA_WIDTH=64, WMASK_GRAN=16, ADDR_WIDTH=3 → 4 mask lanes, 8-edge clear, random read/write traffic matches the reference model with no mismatches.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types and helpers for the two-port cache data array.
package sram_pkg;

  // Clear sequencer state.
  typedef enum logic {StClear, StReady} clr_state_e;

  // Upper bounds for the generic lane-merge helper; callers size-cast in and out.
  localparam int unsigned MaxDataWidth = 1024;
  localparam int unsigned MaxLanes     = 1024;

  // Number of write-mask lanes for a given word width and lane granularity.
  function automatic int unsigned num_wmasks(input int unsigned data_width,
                                             input int unsigned gran);
    return data_width / gran;
  endfunction

  // Lane i takes new_word where mask[i] is set, old_word otherwise.
  function automatic logic [MaxDataWidth-1:0] merge_lanes(
    input logic [MaxDataWidth-1:0] old_word,
    input logic [MaxDataWidth-1:0] new_word,
    input logic [MaxLanes-1:0]     mask,
    input int unsigned             gran
  );
    logic [MaxDataWidth-1:0] merged;
    for (int unsigned b = 0; b < MaxDataWidth; b++) begin
      merged[b] = mask[b / gran] ? new_word[b] : old_word[b];
    end
    return merged;
  endfunction

endpackage

// File: rtl/sram_clear_seq.sv
// Clear sequencer: walks every address once writing the init value, then reports ready.
module sram_clear_seq
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clr_req_i,
  output logic                  ready_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  clr_state_e            state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  ready_q;

  // Single-process FSM: counter advances one word per edge while clearing.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? StClear : StReady;
      cnt_q   <= '0;
      ready_q <= !CLEAR_ON_RESET;
    end else begin
      unique case (state_q)
        StClear: begin
          cnt_q <= cnt_q + ADDR_WIDTH'(1);
          // The edge that writes the last address finishes the sweep.
          if (cnt_q == '1) begin
            state_q <= StReady;
            ready_q <= 1'b1;
          end
        end
        StReady: begin
          if (clr_req_i) begin
            state_q <= StClear;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= StReady;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = (state_q == StClear);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/cache_data_array_2p.sv
// Two-port cache data array: port 0 read/write with lane mask, port 1 read-only,
// registered outputs, write-through forwarding to port 1, built-in clear sequencer.
module cache_data_array_2p
  import sram_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH     = 256,
  parameter int unsigned            ADDR_WIDTH     = 5,
  parameter int unsigned            WMASK_GRAN     = 8,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE     = '0,
  parameter bit                     CLEAR_ON_RESET = 1'b1,
  localparam int unsigned           NUM_WMASKS     = num_wmasks(DATA_WIDTH, WMASK_GRAN)
) (
  input  logic                  clk0,
  input  logic                  rst0_n,
  input  logic                  clr_req,
  output logic                  ready,
  input  logic                  csb0,
  input  logic                  web0,
  input  logic [NUM_WMASKS-1:0] wmask0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] din0,
  output logic [DATA_WIDTH-1:0] dout0,
  input  logic                  csb1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] dout1
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] dout0_q, dout1_q;
  logic [DATA_WIDTH-1:0] merged;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;
  logic                  req_ok, p0_wr, p0_rd, p1_rd;

  sram_clear_seq #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk_i      (clk0),
    .rst_ni     (rst0_n),
    .clr_req_i  (clr_req),
    .ready_o    (ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  // Port requests are only honoured while ready; a clear request wins over them.
  assign req_ok = ready & ~clr_req;
  assign p0_wr  = req_ok & ~csb0 & ~web0;
  assign p0_rd  = req_ok & ~csb0 & web0;
  assign p1_rd  = req_ok & ~csb1;

  // Merged write word; also the forwarded value for a same-address port 1 read.
  always_comb begin
    merged = DATA_WIDTH'(merge_lanes(MaxDataWidth'(mem_q[addr0]), MaxDataWidth'(din0),
                                     MaxLanes'(wmask0), WMASK_GRAN));
  end

  // Storage: clear sweep and port 0 writes are mutually exclusive through ready.
  always_ff @(posedge clk0) begin
    if (clr_we) begin
      mem_q[clr_addr] <= INIT_VALUE;
    end else if (p0_wr) begin
      mem_q[addr0] <= merged;
    end
  end

  // Registered read outputs; deselected or dropped requests hold the last value.
  always_ff @(posedge clk0 or negedge rst0_n) begin
    if (!rst0_n) begin
      dout0_q <= '0;
      dout1_q <= '0;
    end else begin
      if (p0_rd) begin
        dout0_q <= mem_q[addr0];
      end
      if (p1_rd) begin
        dout1_q <= (p0_wr && (addr1 == addr0)) ? merged : mem_q[addr1];
      end
    end
  end

  assign dout0 = dout0_q;
  assign dout1 = dout1_q;

endmodule
